// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle controller and radix-2 shift-add datapath for the
// RV32M MUL group in the EX stage. It accepts one instruction in IDLE and runs
// DATA_W add/shift iterations in BUSY. It then presents the selected product
// word for exactly one cycle in DONE. While the multiply is in flight it asks
// the pipeline to freeze.
//
// Ports:
//   clk     - system clock; all state updates on the rising edge
//   arst_n  - synchronous active-low reset
//   start   - EX stage holds a MUL-group instruction (level)
//   flush   - kill the in-flight multiply (redirect)
//   funct3  - 000 selects the low product word, anything else the high word
//   op_a    - multiplicand (rs1), unsigned
//   op_b    - multiplier (rs2), unsigned
//   result  - product word, valid while done = 1 (registered)
//   done    - one-cycle completion pulse (registered)
//   busy    - high while iterating (registered)
//   stall   - combinational freeze request to PC, IF/ID and ID/EX
//
// Optional feature macro: MUL_EARLY_TERM_EN
//   When defined, BUSY exits as soon as the shifted multiplier is zero. When
//   undefined, BUSY always lasts exactly DATA_W cycles.

module mul_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              stall
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [2*DATA_W-1:0] acc_reg;
  logic [2*DATA_W-1:0] mcand_reg;
  logic [DATA_W-1:0]   mplier_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                sel_reg;

  // One iteration of the datapath, evaluated every cycle but only committed
  // while in BUSY.
  logic [2*DATA_W-1:0] partial_next;
  logic [2*DATA_W-1:0] acc_next;
  logic [2*DATA_W-1:0] mcand_next;
  logic [DATA_W-1:0]   mplier_next;
  logic [CNT_W-1:0]    count_next;
  logic [DATA_W-1:0]   result_next;
  logic                last_iter;

  // Partial product is the multiplicand gated by the current multiplier LSB.
  generate
    for (genvar gi = 0; gi < 2*DATA_W; gi++) begin : g_partial
      assign partial_next[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign acc_next    = acc_reg + partial_next;
  assign mcand_next  = mcand_reg << 1;
  assign mplier_next = mplier_reg >> 1;
  assign count_next  = count_reg + 1'b1;

  // Result is captured on the final BUSY edge from the accumulator value being
  // written. This makes it valid in the same cycle that done goes high.
  assign result_next = sel_reg ? acc_next[DATA_W-1:0] : acc_next[2*DATA_W-1:DATA_W];

`ifdef MUL_EARLY_TERM_EN
  // Once the remaining multiplier bits are all zero, every further partial
  // product is zero too. The accumulator is already final at that point.
  assign last_iter = (count_next == CNT_LAST) || (mplier_next == '0);
`else
  assign last_iter = (count_next == CNT_LAST);
`endif

  // In IDLE the request itself must freeze the front end in the same cycle.
  // This keeps the instruction parked in EX while it is being accepted.
  always_comb begin
    stall = 1'b0;
    case (state_reg)
      IDLE:    stall = start;
      BUSY:    stall = 1'b1;
      DONE:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      sel_reg    <= 1'b0;
      result     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= 1'b0;
      if (flush) begin
        // Datapath registers are left as they are. Only control is cancelled,
        // and result keeps its previous value.
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              acc_reg    <= '0;
              mcand_reg  <= {{DATA_W{1'b0}}, op_a};
              mplier_reg <= op_b;
              count_reg  <= '0;
              sel_reg    <= (funct3 == 3'b000);
              busy       <= 1'b1;
              state_reg  <= BUSY;
            end
          end
          BUSY: begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            count_reg  <= count_next;
            if (last_iter) begin
              result    <= result_next;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              busy <= 1'b1;
            end
          end
          DONE: begin
            // start here still belongs to the retiring instruction.
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller for the RV32M MUL instruction group in the EX stage.
- Sequences an internal radix-2 shift-add multiply datapath over several cycles.
- Drives a stall to the pipeline while the multiply is in progress, then presents a one-cycle result.
- Sits beside the ALU. Started by EX-stage decode when the R-type opcode carries funct7 = 0000001.

Parameters:
- DATA_W, 32, operand and result width; iteration counter width is $clog2(DATA_W)+1.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- arst_n, input, 1, reset; synchronous, active-low.
- start, input, 1, EX stage holds a MUL-group instruction; level, held by the pipeline while stalled.
- flush, input, 1, kill the in-flight multiply (branch/jump redirect).
- funct3, input, 3, operation select: 000 = MUL (low word); 011 = MULHU (high word, unsigned); any other value = high word, unsigned.
- op_a, input, DATA_W, multiplicand (rs1), treated as unsigned.
- op_b, input, DATA_W, multiplier (rs2), treated as unsigned.
- result, output, DATA_W, product word; valid only while done = 1.
- done, output, 1, one-cycle pulse; result is valid.
- busy, output, 1, registered; high in BUSY.
- stall, output, 1, combinational freeze request to PC, IF/ID and ID/EX registers.

Behaviour:
- Reset (arst_n = 0 at a clk edge): state = IDLE; result, done and busy = 0; internal accumulator, multiplicand, multiplier, counter and select all = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = start.
  - On start = 1 and flush = 0: latch {DATA_W zeros, op_a} into 2*DATA_W multiplicand register; latch op_b into multiplier register; latch sel = (funct3 == 000).
  - Also clear acc (2*DATA_W bits) and count; go to BUSY.
  - start = 1 with flush = 1 is ignored; stay IDLE.
- BUSY:
  - stall = 1, busy = 1.
  - Each cycle: if multiplier[0] = 1 then acc += multiplicand (mod 2^(2*DATA_W)).
  - Shift multiplicand left by 1, shift multiplier right by 1, count += 1.
  - When count reaches DATA_W (the last iteration is this cycle): go to DONE.
  - start is ignored (pipeline holds the same instruction).
- DONE:
  - stall = 0, busy = 0.
  - done = 1 for exactly this cycle; result = acc[DATA_W-1:0] if sel, else acc[2*DATA_W-1:DATA_W].
  - Next state is IDLE unconditionally.
  - start in DONE belongs to the retiring instruction and is ignored.
- Latency (no early termination): start sampled at edge 0; BUSY for DATA_W cycles; done high in cycle DATA_W+1. For DATA_W = 32, done is high in cycle 33.
- result and done are registered. Outside DONE, result holds its last value and done = 0.
- flush:
  - In any state, flush = 1 forces IDLE at the next edge.
  - No done pulse is produced; busy = 0 next cycle.
  - The datapath registers need not clear.
  - flush has priority over the BUSY->DONE transition.
- Reset mid-operation: identical to flush, plus clears result.
- Back-to-back MULs: the second is accepted in the IDLE cycle after DONE. Minimum spacing between done pulses is DATA_W+2 cycles.
- op_b = 0 or op_a = 0: runs the full count; result = 0.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - In BUSY, exit to DONE when the post-shift multiplier value is 0, or when count reaches DATA_W, whichever comes first. BUSY always lasts at least 1 cycle.
  - The result is identical to the full run, because remaining partial products are zero.
  - Latency = (index of highest set bit of op_b) + 2 cycles; op_b = 0 gives done in cycle 2.
- Undefined: BUSY always lasts exactly DATA_W cycles; no zero-detect logic is instantiated.

Test Plan:
- op_a = 3, op_b = 5, funct3 = 000, start held -> stall = 1 in cycles 0..32; done = 1 and result = 0x0000000F in cycle 33; stall = 0 in cycle 33.
- op_a = op_b = 0xFFFFFFFF, funct3 = 011 -> result = 0xFFFFFFFE. Rerun with funct3 = 000 -> result = 0x00000001.
- Start a MUL, assert flush in cycle 10 -> no done pulse; busy = 0 and stall = 0 in cycle 11. A new start in cycle 12 with 7*6 -> result = 42, done = 1 in cycle 45.
- During BUSY, change op_a/op_b/funct3 to 9/9/011 -> ignored; the original operands' product appears. start still high in the DONE cycle -> no second multiply begins.
- Assert arst_n = 0 in cycle 20 of a multiply -> next cycle result = 0, done = 0, busy = 0, stall = start.
- With MUL_EARLY_TERM_EN: op_a = 0x1234, op_b = 1 -> done in cycle 2, result = 0x1234; op_b = 0x80000000 -> done in cycle 33, result = 0x00000000 low / 0x0000091A high.
